// File: rtl/tex_qspi_pkg.sv
// Shared state encoding, opcode and phase-length defaults for the texture QSPI reader.
package tex_qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_DONE
  } state_e;

  localparam logic [7:0] CMD_DEFAULT   = 8'h6B;
  localparam int         CMD_BITS      = 8;
  localparam int         ADDR_BITS_DEF = 24;
  localparam int         DATA_BITS_DEF = 24;
  localparam int         DUMMY_DEF     = 8;

  function automatic int nib_count(input int data_bits);
    return data_bits / 4;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/tex_qspi_shift.sv
// Nibble shift-in register; word_o is the stored nibbles with the live nibble appended.
module tex_qspi_shift #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cap_i,
  input  logic [3:0]   nib_i,
  output logic [W-1:0] word_o
);

  logic [W-5:0] sh_q;

  assign word_o = {sh_q, nib_i};

  always_ff @(posedge clk_i) begin
    if (rst_i)      sh_q <= '0;
    else if (cap_i) sh_q <= word_o[W-5:0];
  end

endmodule

// File: rtl/tex_qspi_reader.sv
// Quad Output Fast Read engine: one address in, one DATA_BITS word out, SCLK = clk/2, mode 0.
module tex_qspi_reader
  import tex_qspi_pkg::*;
#(
  parameter int         ADDR_BITS  = ADDR_BITS_DEF,
  parameter int         DATA_BITS  = DATA_BITS_DEF,
  parameter logic [7:0] CMD        = CMD_DEFAULT,
  parameter int         DUMMY_CLKS = DUMMY_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_tex_csb,
  output logic                 o_tex_sclk,
  output logic                 o_tex_oeb0,
  output logic                 o_tex_out0,
  input  logic [3:0]           i_tex_in
);

  localparam int NIB = nib_count(DATA_BITS);
  localparam int CW  = $clog2(max4(ADDR_BITS, DUMMY_CLKS, NIB, CMD_BITS));
  localparam int TXW = CMD_BITS + ADDR_BITS;

  state_e               state_q, state_d;
  logic                 half_q, half_d;
  logic [CW-1:0]        cnt_q, cnt_d, last_cnt;
  logic [TXW-1:0]       tx_q, tx_d;
  logic                 cap;
  logic [DATA_BITS-1:0] word, data_q, data_d;
  logic                 csb_q, sclk_q, oeb0_q, out0_q, valid_q;
  logic                 csb_d, sclk_d, oeb0_d, out0_d, valid_d;

  always_comb begin
    case (state_q)
      ST_CMD:   last_cnt = CW'(CMD_BITS - 1);
      ST_ADDR:  last_cnt = CW'(ADDR_BITS - 1);
      ST_DUMMY: last_cnt = CW'(DUMMY_CLKS - 1);
      default:  last_cnt = CW'(NIB - 1);
    endcase
  end

  // half_q = 1 marks the SCLK-high half; everything advances on the edge that ends it.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: if (i_req) begin
        state_d = ST_START;
        tx_d    = {CMD, i_addr};
      end
      ST_START: begin
        state_d = ST_CMD;
        half_d  = 1'b0;
        cnt_d   = '0;
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        half_d = ~half_q;
        if (half_q) begin
          cap = (state_q == ST_DATA);
          if (state_q inside {ST_CMD, ST_ADDR}) tx_d = tx_q << 1;
          if (cnt_q == last_cnt) begin
            cnt_d = '0;
            case (state_q)
              ST_CMD:   state_d = ST_ADDR;
              ST_ADDR:  state_d = ST_DUMMY;
              ST_DUMMY: state_d = ST_DATA;
              default:  state_d = ST_DONE;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Pad outputs are registered from next state so they change cleanly with the state.
  always_comb begin
    csb_d   = (state_d == ST_IDLE) || (state_d == ST_DONE);
    sclk_d  = half_d && (state_d inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA});
    oeb0_d  = !(state_d inside {ST_START, ST_CMD, ST_ADDR});
    out0_d  = oeb0_d ? 1'b0 : tx_d[TXW-1];
    valid_d = (state_d == ST_DONE);
    data_d  = (cap && state_d == ST_DONE) ? word : data_q;
  end

  tex_qspi_shift #(.W(DATA_BITS)) u_shift (
    .clk_i  (i_clk),
    .rst_i  (i_reset),
    .cap_i  (cap),
    .nib_i  (i_tex_in),
    .word_o (word)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      tx_q    <= '0;
      data_q  <= '0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      oeb0_q  <= 1'b1;
      out0_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      oeb0_q  <= oeb0_d;
      out0_q  <= out0_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_tex_csb  = csb_q;
  assign o_tex_sclk = sclk_q;
  assign o_tex_oeb0 = oeb0_q;
  assign o_tex_out0 = out0_q;

endmodule

// File: tb/tb_tex_qspi_reader.sv
// Bench for tex_qspi_reader: behavioural SPI flash models, scoreboard queues, directed + random steps.
module tb_tex_qspi_reader;

  localparam int         AB    = 24;
  localparam int         DB    = 24;
  localparam int         DC    = 8;
  localparam int         NIB   = DB / 4;
  localparam int         DB_B  = 16;
  localparam int         DC_B  = 4;
  localparam int         NIB_B = DB_B / 4;
  localparam logic [7:0] OPC   = 8'h6B;
  localparam int         LAT_A = 1 + 2 * (8 + AB + DC + NIB) + 1;
  localparam int         LAT_B = 1 + 2 * (8 + AB + DC_B + NIB_B) + 1;
  localparam int         DATA_START_A = 8 + AB + DC;
  localparam int         DATA_START_B = 8 + AB + DC_B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_a = 1'b0, req_b = 1'b0;
  logic [AB-1:0] addr_a = '0, addr_b = '0;
  logic          ready_a, valid_a, csb_a, sclk_a, oeb_a, out0_a;
  logic          ready_b, valid_b, csb_b, sclk_b, oeb_b, out0_b;
  logic [DB-1:0] data_a;
  logic [DB_B-1:0] data_b;
  logic [3:0]    tin_a = '0, tin_b = '0;

  tex_qspi_reader dut_a (
    .i_clk(clk), .i_reset(rst), .i_req(req_a), .i_addr(addr_a),
    .o_ready(ready_a), .o_valid(valid_a), .o_data(data_a),
    .o_tex_csb(csb_a), .o_tex_sclk(sclk_a), .o_tex_oeb0(oeb_a),
    .o_tex_out0(out0_a), .i_tex_in(tin_a)
  );

  tex_qspi_reader #(.DATA_BITS(DB_B), .DUMMY_CLKS(DC_B)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_req(req_b), .i_addr(addr_b),
    .o_ready(ready_b), .o_valid(valid_b), .o_data(data_b),
    .o_tex_csb(csb_b), .o_tex_sclk(sclk_b), .o_tex_oeb0(oeb_b),
    .o_tex_out0(out0_b), .i_tex_in(tin_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash model A: shifts in opcode+address on SCLK rise, returns nibbles after SCLK fall.
  int            rises_a = 0, falls_a = 0, stab_err = 0;
  logic [31:0]   rx_a = '0;
  logic [DB-1:0] cur_a = '0;
  logic          drv_a = 1'b0, low_out0_a = 1'b0;
  logic [DB-1:0] flash_q[$];

  always @(negedge csb_a) begin
    rises_a = 0;
    falls_a = 0;
    rx_a    = '0;
    cur_a   = (flash_q.size() > 0) ? flash_q.pop_front() : '0;
  end
  always @(posedge sclk_a) begin
    if (rises_a < 8 + AB) begin
      rx_a = {rx_a[30:0], out0_a};
      if (out0_a !== low_out0_a) stab_err++;
    end
    rises_a++;
  end
  always @(negedge sclk_a) begin
    falls_a++;
    if (falls_a >= DATA_START_A && falls_a < DATA_START_A + NIB) begin
      tin_a <= 4'(cur_a >> (4 * (NIB - 1 - (falls_a - DATA_START_A))));
      drv_a <= 1'b1;
    end else begin
      tin_a <= '0;
      drv_a <= 1'b0;
    end
  end

  // Flash model B: data return only.
  int              falls_b = 0;
  logic [DB_B-1:0] word_b = '0;
  logic            drv_b = 1'b0;
  always @(negedge csb_b) falls_b = 0;
  always @(negedge sclk_b) begin
    falls_b++;
    if (falls_b >= DATA_START_B && falls_b < DATA_START_B + NIB_B) begin
      tin_b <= 4'(word_b >> (4 * (NIB_B - 1 - (falls_b - DATA_START_B))));
      drv_b <= 1'b1;
    end else begin
      tin_b <= '0;
      drv_b <= 1'b0;
    end
  end

  // Monitor on the falling clock edge; edges are numbered by the posedge count.
  int              acc_q[$], vld_q[$], oeb_q[$], acc_b_q[$], vld_b_q[$];
  logic [DB-1:0]   got_q[$], exp_q[$], exp_addr_q[$];
  logic [DB_B-1:0] got_b_q[$];
  logic [31:0]     rx_q[$];
  int   oeb_lo = 0, hi_run = 0, last_gap = 0, pad_viol = 0, contention = 0;
  logic prev_csb_a = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (req_a && ready_a) acc_q.push_back(cyc + 1);
      if (req_b && ready_b) acc_b_q.push_back(cyc + 1);
      if (valid_a) begin got_q.push_back(data_a); vld_q.push_back(cyc + 1); end
      if (valid_b) begin got_b_q.push_back(data_b); vld_b_q.push_back(cyc + 1); end
    end
    if ((csb_a && sclk_a) || (csb_b && sclk_b)) pad_viol++;
    if ((oeb_a && out0_a) || (oeb_b && out0_b)) pad_viol++;
    if ((drv_a && !oeb_a) || (drv_b && !oeb_b)) contention++;
    if (!sclk_a) low_out0_a = out0_a;
    if (!csb_a && !oeb_a) oeb_lo++;
    if (csb_a) begin
      if (!prev_csb_a) begin
        oeb_q.push_back(oeb_lo);
        rx_q.push_back(rx_a);
        oeb_lo = 0;
      end
      hi_run++;
    end else begin
      if (prev_csb_a) last_gap = hi_run;
      hi_run = 0;
    end
    prev_csb_a = csb_a;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a();
    int n = 0;
    while (!ready_a && n < 300) begin step(); n++; end
    if (!ready_a) chk("ready_timeout", 64'(ready_a), 64'd1);
  endtask

  task automatic issue_a(input logic [DB-1:0] a, input logic [DB-1:0] w);
    wait_ready_a();
    flash_q.push_back(w);
    exp_q.push_back(w);
    exp_addr_q.push_back(a);
    addr_a = a;
    req_a  = 1'b1;
    step();
    req_a  = 1'b0;
    addr_a = DB'($urandom);
  endtask

  task automatic check_a(input string tag);
    int t = 0;
    logic [DB-1:0] w, a;
    int acc, vld, oeb_n;
    logic [31:0] rx;
    while (got_q.size() == 0 && t < 400) begin step(); t++; end
    if (got_q.size() == 0) begin
      chk({tag, "_valid_timeout"}, 64'd0, 64'd1);
      return;
    end
    w = exp_q.pop_front();
    a = exp_addr_q.pop_front();
    acc = acc_q.pop_front();
    vld = vld_q.pop_front();
    rx = rx_q.pop_front();
    oeb_n = oeb_q.pop_front();
    chk({tag, "_data"}, 64'(got_q.pop_front()), 64'(w));
    chk({tag, "_latency"}, 64'(vld - acc), 64'(LAT_A));
    chk({tag, "_cmd_addr"}, 64'(rx), 64'({OPC, a}));
    chk({tag, "_oeb_low_cycles"}, 64'(oeb_n), 64'd65);
    step();
    chk({tag, "_pulse"}, 64'(valid_a), 64'd0);
  endtask

  initial begin
    int n, viol, accb, t;
    logic [DB-1:0] ra, rw;

    // reset state
    repeat (3) step();
    chk("rst_csb", 64'(csb_a), 64'd1);
    chk("rst_sclk", 64'(sclk_a), 64'd0);
    chk("rst_oeb0", 64'(oeb_a), 64'd1);
    chk("rst_out0", 64'(out0_a), 64'd0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_data", 64'(data_a), 64'd0);
    chk("rst_ready", 64'(ready_a), 64'd1);
    rst = 1'b0;

    // idle
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!(csb_a && !sclk_a && oeb_a && ready_a && !valid_a)) viol++;
    end
    chk("idle_pads", 64'(viol), 64'd0);

    // single read
    issue_a(24'h012345, 24'hA5C3F0);
    check_a("t1");

    // back-to-back with req held high
    flash_q.push_back(24'h111111); exp_q.push_back(24'h111111); exp_addr_q.push_back(24'h000000);
    flash_q.push_back(24'hEEEEEE); exp_q.push_back(24'hEEEEEE); exp_addr_q.push_back(24'hFFFFFF);
    wait_ready_a();
    addr_a = 24'h000000;
    req_a  = 1'b1;
    step();
    addr_a = 24'hFFFFFF;
    n = 0;
    while (acc_q.size() < 2 && n < 300) begin step(); n++; end
    req_a = 1'b0;
    chk("b2b_accepts", 64'(acc_q.size()), 64'd2);
    check_a("b2b0");
    check_a("b2b1");
    chk("b2b_csb_gap_ge2", 64'(last_gap >= 2), 64'd1);

    // random reads
    for (int i = 0; i < 4; i++) begin
      ra = DB'($urandom);
      rw = DB'($urandom);
      issue_a(ra, rw);
      check_a("rand");
    end

    // reset mid-address
    issue_a(24'h00ABCD, 24'h123456);
    t = 0;
    while (cyc < acc_q[0] + 40 && t < 100) begin step(); t++; end
    rst = 1'b1;
    step();
    chk("abort_csb", 64'(csb_a), 64'd1);
    chk("abort_sclk", 64'(sclk_a), 64'd0);
    chk("abort_valid", 64'(valid_a), 64'd0);
    rst = 1'b0;
    repeat (120) step();
    chk("abort_no_valid", 64'(got_q.size()), 64'd0);
    chk("abort_data", 64'(data_a), 64'd0);
    exp_q.delete(); exp_addr_q.delete(); acc_q.delete(); rx_q.delete(); oeb_q.delete();
    flash_q.delete();
    issue_a(24'h000010, DB'($urandom));
    check_a("post_abort");

    // narrow-word, short-dummy instance
    for (int i = 0; i < 2; i++) begin
      word_b = (i == 0) ? 16'hBEEF : DB_B'($urandom);
      addr_b = DB'($urandom);
      req_b  = 1'b1;
      step();
      req_b  = 1'b0;
      t = 0;
      while (got_b_q.size() == 0 && t < 400) begin step(); t++; end
      if (got_b_q.size() == 0) chk("sweep_valid_timeout", 64'd0, 64'd1);
      else begin
        accb = acc_b_q.pop_front();
        chk("sweep_data", 64'(got_b_q.pop_front()), 64'(word_b));
        chk("sweep_latency", 64'(vld_b_q.pop_front() - accb), 64'(LAT_B));
      end
      repeat (3) step();
    end

    chk("io0_contention", 64'(contention), 64'd0);
    chk("pad_rules", 64'(pad_viol), 64'd0);
    chk("io0_stable_at_rise", 64'(stab_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tex_qspi_reader.md
Name: tex_qspi_reader

Overview:
- Texture-memory fetch engine inside top_ew_algofoogle; directly drives the texture QSPI pads (csb, sclk, io0 bidir, io[3:1] shared inputs).
- Accepts an address from the texel lookup logic and performs one SPI-flash Quad Output Fast Read (0x6B).
- Returns one DATA_BITS-wide word, e.g. a 24-bit RGB texel.
- SCLK runs at i_clk/2 in SPI mode 0.

Parameters:
ADDR_BITS, 24, flash address width; sent MSB first.
DATA_BITS, 24, returned word width; must be a multiple of 4 (NIB = DATA_BITS/4).
CMD, 8'h6B, read opcode; sent MSB first on io0.
DUMMY_CLKS, 8, SCLK cycles between address and first data nibble.

Ports:
i_clk  in  1  system clock (user_clock2 domain).
i_reset  in  1  synchronous, active-high reset.
i_req  in  1  fetch request; accepted when i_req && o_ready.
i_addr  in  ADDR_BITS  fetch address; sampled on accept.
o_ready  out  1  high only in IDLE.
o_valid  out  1  one-cycle pulse; o_data is valid in that cycle.
o_data  out  DATA_BITS  last fetched word; held until the next o_valid.
o_tex_csb  out  1  flash chip select, active low.
o_tex_sclk  out  1  flash clock.
o_tex_oeb0  out  1  io0 direction: 0 = drive, 1 = input.
o_tex_out0  out  1  io0 output data.
i_tex_in  in  4  io[3:0] input data; [0] = io0.

Behaviour:
- Reset values (from the edge where i_reset is high): state IDLE, o_tex_csb=1, o_tex_sclk=0, o_tex_oeb0=1, o_tex_out0=0, o_valid=0, o_data=0, o_ready=1.
- Reset mid-transaction aborts on the next edge: csb high, sclk low, no o_valid. Partial data is discarded; o_data keeps its reset value.
- States: IDLE -> START -> CMD -> ADDR -> DUMMY -> DATA -> DONE -> IDLE.
- IDLE: on accept, latch i_addr and go to START. i_req without o_ready is ignored, not queued.
- START (1 cycle): csb=0, sclk=0, oeb0=0, out0 = CMD[7].
- Bit phases use a 2-cycle SCLK period. Low half: sclk=0, and out0 is updated at entry (mode 0: change on falling edge). High half: sclk=1.
  - Bit counter advances at the end of each high half.
  - CMD: 8 bits. ADDR: ADDR_BITS bits. Both have oeb0=0.
- DUMMY: DUMMY_CLKS periods. oeb0=1 from the first DUMMY cycle; out0=0.
- DATA: NIB periods.
  - Shift register captures i_tex_in[3:0] on the i_clk edge ending each high half (the same edge that drives sclk 1->0).
  - First nibble is most significant; within a nibble, io3 is the MSB.
- DONE (1 cycle): csb=1, sclk=0, oeb0=1. o_data <= shift register; o_valid=1; o_ready=0.
  - The next cycle is IDLE, which guarantees at least 2 cycles of csb high between transactions.
- Latency, with accept at edge E (defaults):
  - csb falls at E+1.
  - o_valid high during cycle E+1+2*(8+24+8+6)+1 = E+94.
  - Next accept possible at edge E+95.
- sclk is never high while csb is high. No sclk glitch at START/DONE boundaries.
- Counters wrap-free. Bit-counter width = clog2(max(ADDR_BITS, DUMMY_CLKS, NIB, 8)).

Decomposition:
- Package tex_qspi_pkg: state encoding (7 states, localparams), CMD default, phase-length constants, nibble-count function.
- No sub-module needed. Optionally split tex_qspi_shift (nibble shift-in register with a capture enable) for reuse by the vector-SPI path.

Test Plan:
- Reset then idle 20 cycles -> csb=1, sclk=0, oeb0=1, o_ready=1, o_valid=0 throughout.
- Req addr 24'h012345, flash model returns 0xA5C3F0 -> io0 carries 0x6B then 0x012345 MSB first, each bit stable across its sclk rising edge. Dummy = 8 sclk. o_data=24'hA5C3F0 with a single o_valid pulse at accept+94 cycles.
- Back-to-back: i_req held high with addr 0x000000 then 0xFFFFFF -> second csb fall no earlier than 2 cycles after first csb rise. Data 0x111111 then 0xEEEEEE returned in order.
- Direction check: oeb0=0 only during START/CMD/ADDR (exactly 1+64 cycles). Model drives io0 only while oeb0=1 -> zero contention cycles reported.
- Reset asserted at cycle 40 after accept (mid-ADDR) -> csb=1 and sclk=0 the next cycle, no o_valid. A subsequent req for 0x000010 completes correctly.
- Parameter sweep DATA_BITS=16, DUMMY_CLKS=4, model data 0xBEEF -> o_data=16'hBEEF, o_valid at accept+1+2*(8+24+4+4)+1 = accept+82.
